// File: rtl/servo_slew_limiter.sv
// Slew-rate limiter between the processor's target position and the servo PWM duty word.
// The duty word moves toward a clamped target by at most STEP counts once per servo frame.
module servo_slew_limiter #(
    parameter int unsigned DUTY_WIDTH   = 10,
    parameter int unsigned SYS_FREQ_MHZ = 25,
    parameter int unsigned FRAME_NS     = 20_000_000,
    parameter int unsigned STEP         = 2,
    parameter int unsigned MIN_DUTY     = 51,
    parameter int unsigned MAX_DUTY     = 102,
    parameter int unsigned DUTY_INIT    = 77
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DUTY_WIDTH-1:0] wr_target,
    output logic [DUTY_WIDTH-1:0] duty_cycle,
    output logic                  frame_tick,
    output logic                  at_target,
    output logic                  busy
);

    localparam int unsigned FRAME_CYCLES = FRAME_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned DW1          = DUTY_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [DUTY_WIDTH-1:0] MIN_D    = DUTY_WIDTH'(MIN_DUTY);
    localparam logic [DUTY_WIDTH-1:0] MAX_D    = DUTY_WIDTH'(MAX_DUTY);
    localparam logic [DUTY_WIDTH-1:0] INIT_D   = DUTY_WIDTH'(DUTY_INIT);
    localparam logic [DUTY_WIDTH:0]   STEP_W   = DW1'(STEP);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RAMP_UP   = 2'd1;
    localparam logic [1:0] RAMP_DOWN = 2'd2;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic [DUTY_WIDTH-1:0] target_q, target_d;
    logic [DUTY_WIDTH-1:0] duty_q, duty_d;

    logic [1:0]            state;
    logic [DUTY_WIDTH:0]   diff_up, diff_dn;
    logic [DUTY_WIDTH:0]   step_up, step_dn;

    // Tick is registered from the next counter value so it is high while the counter is last.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_LAST);
    end

    always_comb begin
        target_d = target_q;
        if (wr_en) begin
            if (wr_target < MIN_D) begin
                target_d = MIN_D;
            end else if (wr_target > MAX_D) begin
                target_d = MAX_D;
            end else begin
                target_d = wr_target;
            end
        end
    end

    always_comb begin
        diff_up = {1'b0, target_q} - {1'b0, duty_q};
        diff_dn = {1'b0, duty_q} - {1'b0, target_q};
        step_up = (diff_up < STEP_W) ? diff_up : STEP_W;
        step_dn = (diff_dn < STEP_W) ? diff_dn : STEP_W;

        if (duty_q == target_q) begin
            state = IDLE;
        end else if (duty_q < target_q) begin
            state = RAMP_UP;
        end else begin
            state = RAMP_DOWN;
        end

        duty_d = duty_q;
        if (tick_q) begin
            case (state)
                RAMP_UP:   duty_d = DUTY_WIDTH'({1'b0, duty_q} + step_up);
                RAMP_DOWN: duty_d = DUTY_WIDTH'({1'b0, duty_q} - step_dn);
                default:   duty_d = duty_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            target_q <= INIT_D;
            duty_q   <= INIT_D;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            target_q <= target_d;
            duty_q   <= duty_d;
        end
    end

    always_comb begin
        duty_cycle = duty_q;
        frame_tick = tick_q;
        at_target  = (duty_q == target_q);
        busy       = ~at_target;
    end

endmodule

// File: doc/servo_slew_limiter.md
# servo_slew_limiter

Upstream stage of the servo PWM path: accepts an absolute target position from the processor and drives the 10-bit duty-cycle word consumed by the servo PWM driver. The duty word moves toward the target by at most STEP counts per servo frame, never beyond [MIN_DUTY, MAX_DUTY]. Updates are aligned to an internal 20 ms frame tick, so the PWM driver sees at most one duty change per servo period.

## Interface
- DUTY_WIDTH, 10: width of target and duty words (0–1023 full scale).
- SYS_FREQ_MHZ, 25: clock frequency in MHz.
- FRAME_NS, 20_000_000: servo frame period in ns. FRAME_CYCLES = FRAME_NS*SYS_FREQ_MHZ/1000 (500_000 at defaults).
- STEP, 2: maximum duty change per frame, ≥1.
- MIN_DUTY, 51: lower clamp (≈1.0 ms pulse).
- MAX_DUTY, 102: upper clamp (≈2.0 ms pulse).
- DUTY_INIT, 77: duty and target value after reset (≈1.5 ms, centre). Must lie in [MIN_DUTY, MAX_DUTY].

Ports:
- clk  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle strobe; loads wr_target.
- wr_target  in  DUTY_WIDTH  requested position.
- duty_cycle  out  DUTY_WIDTH  registered duty word to the PWM driver.
- frame_tick  out  1  one-cycle pulse at frame boundary.
- at_target  out  1  high when duty_cycle == target.
- busy  out  1  inverse of at_target.

## Operation
- Frame counter width is $clog2(FRAME_CYCLES). It counts 0..FRAME_CYCLES-1 and wraps to 0.
- frame_tick is registered and high for the one cycle in which the counter equals FRAME_CYCLES-1.
- Target register:
  - On wr_en, load clamp(wr_target) = MIN_DUTY if below, MAX_DUTY if above, else wr_target.
  - wr_en is accepted every cycle; there is no backpressure. The last write wins.
- States:
  - IDLE: duty == target.
  - RAMP_UP: duty < target.
  - RAMP_DOWN: duty > target.
  - The state is re-evaluated every cycle from the registered duty and target.
- Transitions happen only on a frame_tick cycle:
  - RAMP_UP: duty <= duty + min(STEP, target-duty).
  - RAMP_DOWN: duty <= duty - min(STEP, duty-target).
  - IDLE: duty holds.
- Arithmetic:
  - Differences are computed in DUTY_WIDTH+1 bits, unsigned.
  - No overshoot is allowed. The final step lands exactly on target.
- A write during a ramp retargets the ramp. The direction may reverse at the next tick, with no extra dead frame.
- at_target and busy are combinational from the registered duty and target. They may change the cycle after a write, without waiting for a tick.

## Timing
- Reset (reset=0, asynchronous):
  - counter=0, frame_tick=0.
  - duty_cycle=DUTY_INIT, target=DUTY_INIT.
  - at_target=1, busy=0.
- First frame_tick after reset release is in cycle FRAME_CYCLES-1, counting the first cycle with reset=1 as cycle 0.
- duty_cycle changes only on the clock edge that ends a frame_tick cycle. The new value is visible in the cycle following frame_tick.
- Write latency: target is updated on the edge ending the wr_en cycle. at_target reflects the new target one cycle after wr_en.
- wr_en coincident with frame_tick: that tick's step uses the old target. The new target governs from the next tick.
- Ramp length from D to T is ceil(|T-D|/STEP) frame ticks.
- Reset asserted mid-ramp: all state returns to reset values immediately. No partial step is applied.
- duty_cycle never leaves [MIN_DUTY, MAX_DUTY] in any cycle.

## Test plan
Benches override FRAME_NS=400 at SYS_FREQ_MHZ=25, giving FRAME_CYCLES=10.
- Reset check: hold reset=0, release, count cycles.
  - duty_cycle=77, at_target=1 throughout.
  - frame_tick first high in cycle 9, then every 10 cycles.
- Ramp up: write 90 at cycle 2.
  - at_target=0 from cycle 3.
  - duty steps 79, 81, …, 89, 90 on successive ticks: 7 ticks.
  - at_target=1 after the last step, with no overshoot.
- Clamp: write 1000, then later write 0.
  - target becomes 102, and duty ramps up to exactly 102.
  - target then becomes 51, and duty ramps down to exactly 51.
- Reversal and coincidence: with duty ramping up at 85 toward 100, write 80 in the same cycle as frame_tick.
  - That tick gives 87 (old target).
  - Following ticks give 85, 83, 81, 80.
- Reset mid-ramp: pull reset low between ticks during a ramp.
  - duty_cycle=77 and frame_tick=0 immediately, asynchronously.
  - Counter restarts from 0 on release.
- Back-to-back writes: wr_en on 3 consecutive cycles with 60, 95, 70.
  - target=70.
  - duty ramps 77→75→73→71→70.
